// File: rtl/pq_path_driver_if.sv
// Host request/response and path command/response signals of the priority-queue path driver.
// slave is the driver's view; master is the host plus path side.
interface pq_path_driver_if #(
    parameter int PQ_CAP    = 16,
    parameter int RSP_DEPTH = 4
);
    localparam int OCC_W = $clog2(PQ_CAP + 1);
    localparam int OUT_W = $clog2(RSP_DEPTH + 1);

    logic             push_valid;
    logic             push_ready;
    logic [30:0]      push_key;
    logic [31:0]      push_data;
    logic             pop_valid;
    logic             pop_ready;
    logic [64:0]      path_cmd;
    logic [65:0]      path_rsp;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_empty;
    logic [30:0]      rsp_key;
    logic [31:0]      rsp_data;
    logic [OCC_W-1:0] occupancy;
    logic [OUT_W-1:0] outstanding;
    logic             err_unexpected;

    modport slave (
        input  push_valid, push_key, push_data, pop_valid, rsp_ready, path_rsp,
        output push_ready, pop_ready, path_cmd, rsp_valid, rsp_empty, rsp_key, rsp_data,
               occupancy, outstanding, err_unexpected
    );

    modport master (
        output push_valid, push_key, push_data, pop_valid, rsp_ready, path_rsp,
        input  push_ready, pop_ready, path_cmd, rsp_valid, rsp_empty, rsp_key, rsp_data,
               occupancy, outstanding, err_unexpected
    );
endinterface

// File: rtl/pq_path_driver.sv
// Host-side initiator for the priority-queue path: push/pop arbitration into one registered
// command per cycle, plus a credit-protected response FIFO fed by the path.
module pq_path_driver #(
    parameter int PATH_LAT  = 3,
    parameter int RSP_DEPTH = 4,
    parameter int PQ_CAP    = 16
) (
    input  logic           system1000,
    input  logic           system1000_rst,
    pq_path_driver_if.slave bus
);
    localparam int OCC_W = $clog2(PQ_CAP + 1);
    localparam int OUT_W = $clog2(RSP_DEPTH + 1);
    localparam int PW    = $clog2(RSP_DEPTH);

    if (PATH_LAT < 1 || RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_param_chk
        $error("pq_path_driver: PATH_LAT must be >=1, RSP_DEPTH a power of 2 >=2");
    end

    typedef struct packed {
        logic        empty;
        logic [30:0] key;
        logic [31:0] data;
    } rsp_t;

    logic             rr_pop_q, rr_pop_d;
    logic [64:0]      cmd_q, cmd_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             err_q;
    rsp_t             mem [RSP_DEPTH];
    rsp_t             head;

    logic has_room, pop_ready_raw, push_elig, pop_elig;
    logic push_acc, pop_acc, rsp_in, rsp_out, unexp;
    logic unused_key_msb;

    assign unused_key_msb = bus.path_rsp[63];

    assign has_room      = occ_q < OCC_W'(PQ_CAP);
    // Credits count both in-flight pops and queued responses, so the FIFO can never overflow.
    assign pop_ready_raw = ({1'b0, out_q} + {1'b0, cnt_q}) < (OUT_W + 1)'(RSP_DEPTH);
    assign push_elig     = bus.push_valid & has_room;
    assign pop_elig      = bus.pop_valid & pop_ready_raw;

    assign bus.push_ready = has_room & ~(pop_elig & rr_pop_q);
    assign bus.pop_ready  = pop_ready_raw & ~(push_elig & ~rr_pop_q);

    assign push_acc = bus.push_valid & bus.push_ready;
    assign pop_acc  = bus.pop_valid & bus.pop_ready;
    assign rsp_in   = bus.path_rsp[65] & (out_q != '0);
    assign unexp    = bus.path_rsp[65] & (out_q == '0);
    assign rsp_out  = (cnt_q != '0) & bus.rsp_ready;

    always_comb begin
        rr_pop_d = rr_pop_q;
        cmd_d    = '0;
        occ_d    = occ_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        if (push_elig & pop_elig)
            rr_pop_d = ~rr_pop_q;
        if (push_acc) begin
            cmd_d = {1'b1, 1'b0, bus.push_key, bus.push_data};
            occ_d = occ_q + OCC_W'(1);
        end else if (pop_acc) begin
            cmd_d = {1'b1, 1'b1, 63'd0};
            // A pop on an empty queue still goes to the path, which answers "empty".
            if (occ_q != '0)
                occ_d = occ_q - OCC_W'(1);
        end
        case ({pop_acc, rsp_in})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase
        case ({rsp_in, rsp_out})
            2'b10:   cnt_d = cnt_q + OUT_W'(1);
            2'b01:   cnt_d = cnt_q - OUT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            rr_pop_q <= 1'b0;
            cmd_q    <= '0;
            occ_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_pop_q <= rr_pop_d;
            cmd_q    <= cmd_d;
            occ_q    <= occ_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            if (rsp_in)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rsp_out)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (unexp)
                err_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge system1000) begin
        if (rsp_in)
            mem[wr_ptr_q] <= '{empty: bus.path_rsp[64], key: bus.path_rsp[62:32],
                               data: bus.path_rsp[31:0]};
    end

    assign head = mem[rd_ptr_q];

    assign bus.path_cmd       = cmd_q;
    assign bus.rsp_valid      = cnt_q != '0;
    assign bus.rsp_empty      = bus.rsp_valid & head.empty;
    assign bus.rsp_key        = bus.rsp_valid ? head.key  : '0;
    assign bus.rsp_data       = bus.rsp_valid ? head.data : '0;
    assign bus.occupancy      = occ_q;
    assign bus.outstanding    = out_q;
    assign bus.err_unexpected = err_q;
endmodule

// File: tb/tb_pq_path_driver.sv
// Bench for pq_path_driver: a priority-queue path model behind the driver, a host-side reference
// queue that predicts every response, and command/response scoreboards.
module tb_pq_path_driver;
    localparam int PATH_LAT  = 3;
    localparam int RSP_DEPTH = 4;
    localparam int PQ_CAP    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pq_path_driver_if #(.PQ_CAP(PQ_CAP), .RSP_DEPTH(RSP_DEPTH)) bus ();

    pq_path_driver #(.PATH_LAT(PATH_LAT), .RSP_DEPTH(RSP_DEPTH), .PQ_CAP(PQ_CAP)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference queue (host view) and path model queue
    logic [30:0] rk[$];
    logic [31:0] rd[$];
    logic [30:0] pk[$];
    logic [31:0] pd[$];
    logic [65:0] rsp_exp[$];
    logic [64:0] cmd_exp[$];
    logic [65:0] dly [PATH_LAT];
    int          ref_occ = 0, ref_out = 0, ref_out0, m;
    logic        ref_err = 1'b0;
    logic        inj = 1'b0, log_en = 1'b0, pa, qa;
    logic [65:0] nxt;
    int          gl[$];

    function automatic int min_idx(input logic [30:0] ks[$]);
        int mi = 0;
        for (int i = 1; i < ks.size(); i++)
            if (ks[i] < ks[mi]) mi = i;
        return mi;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            rk.delete(); rd.delete(); pk.delete(); pd.delete();
            rsp_exp.delete(); cmd_exp.delete();
            for (int i = 0; i < PATH_LAT; i++) dly[i] = '0;
            ref_occ = 0; ref_out = 0; ref_err = 1'b0;
            bus.path_rsp = '0;
        end else begin
            ref_out0 = ref_out;
            chk("occupancy", 66'(bus.occupancy), 66'(ref_occ));
            chk("outstanding", 66'(bus.outstanding), 66'(ref_out));
            chk("err_unexpected", 66'(bus.err_unexpected), 66'(ref_err));
            if (cmd_exp.size() != 0) chk("path_cmd", 66'(bus.path_cmd), 66'(cmd_exp.pop_front()));
            else                     chk("path_cmd_idle", 66'(bus.path_cmd), 66'd0);

            // path model
            nxt = '0;
            if (bus.path_cmd[64]) begin
                if (!bus.path_cmd[63]) begin
                    pk.push_back(bus.path_cmd[62:32]);
                    pd.push_back(bus.path_cmd[31:0]);
                end else if (pk.size() == 0) begin
                    nxt = {2'b11, 64'd0};
                end else begin
                    m = min_idx(pk);
                    nxt = {2'b10, 1'b0, pk[m], pd[m]};
                    pk.delete(m); pd.delete(m);
                end
            end
            for (int i = PATH_LAT - 1; i > 0; i--) dly[i] = dly[i-1];
            dly[0] = nxt;
            bus.path_rsp = inj ? {3'b101, 31'h1234, 32'hDEAD} : dly[PATH_LAT-1];
            if (bus.path_rsp[65] && ref_out0 == 0) ref_err = 1'b1;

            // host-side acceptances drive the reference predictions
            pa = bus.push_valid & bus.push_ready;
            qa = bus.pop_valid & bus.pop_ready;
            if (bus.push_valid && bus.pop_valid) chk("one_grant", 66'(pa & qa), 66'd0);
            if (log_en) gl.push_back(pa ? 1 : (qa ? 2 : 0));
            if (pa) begin
                rk.push_back(bus.push_key); rd.push_back(bus.push_data);
                ref_occ++;
                cmd_exp.push_back({2'b10, bus.push_key, bus.push_data});
            end
            if (qa) begin
                cmd_exp.push_back({2'b11, 63'd0});
                ref_out++;
                if (rk.size() == 0) rsp_exp.push_back({2'b11, 64'd0});
                else begin
                    m = min_idx(rk);
                    rsp_exp.push_back({2'b10, 1'b0, rk[m], rd[m]});
                    rk.delete(m); rd.delete(m);
                    ref_occ--;
                end
            end
            if (bus.path_rsp[65] && ref_out0 != 0) ref_out--;

            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_exp.size() == 0) chk("rsp_spurious", 66'(bus.rsp_valid), 66'd0);
                else chk("rsp_head", {1'b1, bus.rsp_empty, 1'b0, bus.rsp_key, bus.rsp_data},
                         rsp_exp.pop_front());
            end
        end
    end

    // All host tasks start and end at posedge+1.
    task automatic push(input logic [30:0] k, input logic [31:0] d);
        int t = 0;
        bus.push_valid = 1'b1; bus.push_key = k; bus.push_data = d;
        forever begin
            @(negedge clk);
            if (bus.push_ready) break;
            if (++t >= 100) begin chk("push_timeout", 66'(bus.push_ready), 66'd1); break; end
        end
        @(posedge clk); #1;
        bus.push_valid = 1'b0;
    endtask

    task automatic pop();
        int t = 0;
        bus.pop_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.pop_ready) break;
            if (++t >= 100) begin chk("pop_timeout", 66'(bus.pop_ready), 66'd1); break; end
        end
        @(posedge clk); #1;
        bus.pop_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((rsp_exp.size() != 0 || cmd_exp.size() != 0 || bus.outstanding != '0) && t < 200) begin
            @(negedge clk); t++;
        end
        if (t >= 200) chk("drain_timeout", 66'(rsp_exp.size()) + 66'(bus.outstanding), 66'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.push_valid = 1'b0; bus.push_key = '0; bus.push_data = '0;
        bus.pop_valid = 1'b0; bus.rsp_ready = 1'b1; bus.path_rsp = '0;

        // reset state
        #1;
        chk("rst_path_cmd", 66'(bus.path_cmd), 66'd0);
        chk("rst_rsp_valid", 66'(bus.rsp_valid), 66'd0);
        chk("rst_rsp_fields", {1'b0, bus.rsp_empty, 1'b0, bus.rsp_key, bus.rsp_data}, 66'd0);
        chk("rst_occupancy", 66'(bus.occupancy), 66'd0);
        chk("rst_outstanding", 66'(bus.outstanding), 66'd0);
        chk("rst_err", 66'(bus.err_unexpected), 66'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: push then pop returns the pushed entry
        push(31'd5, 32'hA);
        chk("t1_occ_after_push", 66'(bus.occupancy), 66'd1);
        pop();
        chk("t1_outstanding", 66'(bus.outstanding), 66'd1);
        wait_drain();
        chk("t1_occ_end", 66'(bus.occupancy), 66'd0);

        // 2: pop on empty queue
        pop();
        chk("t2_cmd", 66'(bus.path_cmd), 66'h1_8000_0000_0000_0000);
        wait_drain();
        chk("t2_occ", 66'(bus.occupancy), 66'd0);

        // 3: credit stall with host not consuming
        push(31'd9, 32'h90); push(31'd3, 32'h30); push(31'd7, 32'h70);
        push(31'd1, 32'h10); push(31'd8, 32'h80); push(31'd2, 32'h20);
        bus.rsp_ready = 1'b0;
        bus.pop_valid = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.pop_ready) n++;
        end
        chk("t3_accepted", 66'(n), 66'd4);
        chk("t3_pop_ready", 66'(bus.pop_ready), 66'd0);
        chk("t3_rsp_valid", 66'(bus.rsp_valid), 66'd1);
        chk("t3_head_key", 66'(bus.rsp_key), 66'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 100 && n < 6; t++) begin
            @(negedge clk);
            if (bus.pop_ready) n++;
        end
        @(posedge clk); #1;
        bus.pop_valid = 1'b0;
        chk("t3_total_pops", 66'(n), 66'd6);
        wait_drain();

        // 4: contested requests alternate push, pop, push, pop
        gl.delete();
        bus.push_valid = 1'b1; bus.pop_valid = 1'b1; log_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.push_key = 31'(20 + i); bus.push_data = 32'(i);
            @(posedge clk); #1;
        end
        bus.push_valid = 1'b0; bus.pop_valid = 1'b0; log_en = 1'b0;
        chk("t4_grant_count", 66'(gl.size()), 66'd4);
        if (gl.size() == 4) begin
            chk("t4_grant0", 66'(gl[0]), 66'd1);
            chk("t4_grant1", 66'(gl[1]), 66'd2);
            chk("t4_grant2", 66'(gl[2]), 66'd1);
            chk("t4_grant3", 66'(gl[3]), 66'd2);
        end
        wait_drain();

        // 5: capacity limit
        for (int i = 0; i < PQ_CAP; i++) push(31'(100 - i), 32'(i));
        @(negedge clk);
        chk("t5_occ_full", 66'(bus.occupancy), 66'd16);
        chk("t5_push_ready_full", 66'(bus.push_ready), 66'd0);
        @(posedge clk); #1;
        pop();
        @(negedge clk);
        chk("t5_push_ready_after", 66'(bus.push_ready), 66'd1);
        @(posedge clk); #1;
        wait_drain();

        // 6: unexpected response, then asynchronous reset mid-stream
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        @(posedge clk); #1;
        chk("t6_err", 66'(bus.err_unexpected), 66'd1);
        chk("t6_fifo_unchanged", 66'(bus.rsp_valid), 66'd0);
        bus.push_valid = 1'b1; bus.push_key = 31'd3; bus.push_data = 32'h33;
        bus.pop_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_cmd", 66'(bus.path_cmd), 66'd0);
        chk("t6_rst_rsp", {bus.rsp_valid, bus.rsp_empty, 1'b0, bus.rsp_key, bus.rsp_data}, 66'd0);
        chk("t6_rst_occ", 66'(bus.occupancy), 66'd0);
        chk("t6_rst_out", 66'(bus.outstanding), 66'd0);
        chk("t6_rst_err", 66'(bus.err_unexpected), 66'd0);
        bus.push_valid = 1'b0; bus.pop_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(31'd7, 32'h77);
        pop();
        wait_drain();
        chk("t6_post_occ", 66'(bus.occupancy), 66'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
